// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU
// operation codes, datapath mux selects, instruction classes and FSM states.
// Optional feature macro: MULTICYCLE_JUMP_EN (adds the JUMP state for J/JAL).
package mips_ctrl_pkg;

  // Opcode field values (6-bit MIPS encoding)
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation codes
  localparam logic [2:0] ALU_LUI   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  // Datapath mux selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_REG     = 1'b1;
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  typedef enum logic [2:0] {
    CLS_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
  } instr_class_t;

  // FSM state encoding
  localparam int STATE_W = 4;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_WB_ALU   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [3:0] S_JUMP     = 4'd11;
`endif
  localparam logic [3:0] S_HALT     = 4'd12;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational opcode classifier: maps an opcode to its instruction class
// and, for immediate ALU instructions, the ALU operation to use.
// Optional feature macro: MULTICYCLE_JUMP_EN (J/JAL classified as CLS_JUMP,
// otherwise they fall out as CLS_ILLEGAL).
module mc_opcode_class import mips_ctrl_pkg::*; #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_t        cls,
  output logic [ALU_OP_W-1:0] alu_op
);

  // Classify opcode; unknown opcodes default to illegal
  always_comb begin
    cls    = CLS_ILLEGAL;
    alu_op = ALU_OP_W'(ALU_ADD);
    case (opcode)
      OPCODE_W'(OP_RTYPE): cls = CLS_R;
      OPCODE_W'(OP_ADDI):  begin cls = CLS_ALU_I; alu_op = ALU_OP_W'(ALU_ADD); end
      OPCODE_W'(OP_ORI):   begin cls = CLS_ALU_I; alu_op = ALU_OP_W'(ALU_OR);  end
      OPCODE_W'(OP_ANDI):  begin cls = CLS_ALU_I; alu_op = ALU_OP_W'(ALU_AND); end
      OPCODE_W'(OP_LUI):   begin cls = CLS_ALU_I; alu_op = ALU_OP_W'(ALU_LUI); end
      OPCODE_W'(OP_LW):    cls = CLS_LOAD;
      OPCODE_W'(OP_SW):    cls = CLS_STORE;
      OPCODE_W'(OP_BEQ),
      OPCODE_W'(OP_BNE):   cls = CLS_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
      OPCODE_W'(OP_J),
      OPCODE_W'(OP_JAL):   cls = CLS_JUMP;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit. Moore FSM that walks one instruction at a
// time through FETCH/DECODE/EXEC/MEM/WB and drives the datapath controls.
// Optional feature macro: MULTICYCLE_JUMP_EN (J/JAL via a JUMP state).
//
// Memory handshake: mem_read_o / mem_write_o request an access and stay high
// while the FSM waits; the access completes in the cycle mem_ready_i is high,
// and only then do ir_write/pc_write (FETCH) or the state advance. If
// MEM_TIMEOUT waiting cycles pass without mem_ready_i the FSM parks in HALT
// with bus_error_o set until reset. state_o exposes the FSM state for debug.
module multicycle_control import mips_ctrl_pkg::*; #(
  parameter int OPCODE_W    = 6,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_beq_o,
  output logic                pc_write_bne_o,
  output logic [1:0]          pc_src_o,
  output logic                ir_write_o,
  output logic                i_or_d_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic                reg_dst_o,
  output logic                reg_write_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                instr_done_o,
  output logic                illegal_op_o,
  output logic                bus_error_o,
  output logic [STATE_W-1:0]  state_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [STATE_W-1:0]  state, state_next;
  logic [OPCODE_W-1:0] opcode_q;
  logic [OPCODE_W-1:0] cls_opcode;
  logic [CNT_W-1:0]    wait_cnt;
  logic [ALU_OP_W-1:0] imm_alu_op;
  instr_class_t        cls;
  logic                mem_wait;
  logic                timed_out;

  // DECODE classifies the live opcode; later states use the latched copy
  assign cls_opcode = (state == S_DECODE) ? opcode_i : opcode_q;

  mc_opcode_class #(.OPCODE_W(OPCODE_W), .ALU_OP_W(ALU_OP_W)) u_class (
    .opcode (cls_opcode),
    .cls    (cls),
    .alu_op (imm_alu_op)
  );

  assign mem_wait  = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR))
                     && !mem_ready_i;
  // Ready in the last allowed cycle is not a timeout: mem_wait already excludes it
  assign timed_out = mem_wait && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign state_o   = state;

  // Next-state sequencing
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     state_next = S_FETCH;
      S_FETCH:    if (mem_ready_i) state_next = S_DECODE;
                  else if (timed_out) state_next = S_HALT;
      S_DECODE: begin
        case (cls)
          CLS_R:                state_next = S_EXEC_R;
          CLS_ALU_I:            state_next = S_EXEC_I;
          CLS_LOAD, CLS_STORE:  state_next = S_MEM_ADDR;
          CLS_BRANCH:           state_next = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
          CLS_JUMP:             state_next = S_JUMP;
`endif
          default:              state_next = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
      S_MEM_ADDR: state_next = (cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready_i) state_next = S_WB_MEM;
                  else if (timed_out) state_next = S_HALT;
      S_MEM_WR:   if (mem_ready_i) state_next = S_FETCH;
                  else if (timed_out) state_next = S_HALT;
      S_WB_MEM, S_WB_ALU, S_BRANCH: state_next = S_FETCH;
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP:     state_next = S_FETCH;
`endif
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_IDLE;
    endcase
  end

  // State, opcode latch and memory wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      opcode_q <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) opcode_q <= opcode_i;
      if ((state_next != state) || mem_ready_i) wait_cnt <= '0;
      else if (mem_wait) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Moore outputs decoded from state (FETCH/MEM_WR enables gated by ready)
  always_comb begin
    pc_write_o     = 1'b0;
    pc_write_beq_o = 1'b0;
    pc_write_bne_o = 1'b0;
    pc_src_o       = PC_SRC_ALU;
    ir_write_o     = 1'b0;
    i_or_d_o       = 1'b0;
    mem_read_o     = 1'b0;
    mem_write_o    = 1'b0;
    mem_to_reg_o   = 1'b0;
    reg_dst_o      = 1'b0;
    reg_write_o    = 1'b0;
    alu_src_a_o    = SRC_A_PC;
    alu_src_b_o    = SRC_B_REG;
    alu_op_o       = '0;
    instr_done_o   = 1'b0;
    illegal_op_o   = 1'b0;
    bus_error_o    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRC_B_FOUR;
        alu_op_o    = ALU_OP_W'(ALU_ADD);
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o  = SRC_B_IMM_SH2;
        alu_op_o     = ALU_OP_W'(ALU_ADD);
        illegal_op_o = (cls == CLS_ILLEGAL);
      end
      S_EXEC_R: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_REG;
        alu_op_o    = ALU_OP_W'(ALU_RTYPE);
      end
      S_EXEC_I: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = imm_alu_op;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = SRC_A_REG;
        alu_src_b_o = SRC_B_IMM;
        alu_op_o    = ALU_OP_W'(ALU_ADD);
      end
      S_MEM_RD: begin
        i_or_d_o   = 1'b1;
        mem_read_o = 1'b1;
      end
      S_MEM_WR: begin
        i_or_d_o     = 1'b1;
        mem_write_o  = 1'b1;
        instr_done_o = mem_ready_i;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
      end
      S_WB_ALU: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (cls == CLS_R);
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o    = SRC_A_REG;
        alu_src_b_o    = SRC_B_REG;
        alu_op_o       = ALU_OP_W'(ALU_SUB);
        pc_src_o       = PC_SRC_ALUOUT;
        pc_write_beq_o = (opcode_q == OPCODE_W'(OP_BEQ));
        pc_write_bne_o = (opcode_q == OPCODE_W'(OP_BNE));
        instr_done_o   = 1'b1;
      end
`ifdef MULTICYCLE_JUMP_EN
      S_JUMP: begin
        pc_write_o   = 1'b1;
        pc_src_o     = PC_SRC_JUMP;
        reg_write_o  = (opcode_q == OPCODE_W'(OP_JAL));
        instr_done_o = 1'b1;
      end
`endif
      S_HALT: bus_error_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control. Inputs are driven on the falling
// edge and outputs sampled 1 time unit later. Expected output vectors are
// written out per state by hand. Honours MULTICYCLE_JUMP_EN for J/JAL.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o, pc_write_beq_o, pc_write_bne_o;
  logic [1:0] pc_src_o;
  logic       ir_write_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic       instr_done_o, illegal_op_o, bus_error_o;
  logic [3:0] state_o;
  logic [20:0] outs;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.OPCODE_W(6), .ALU_OP_W(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_beq_o(pc_write_beq_o),
    .pc_write_bne_o(pc_write_bne_o), .pc_src_o(pc_src_o),
    .ir_write_o(ir_write_o), .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
    .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .instr_done_o(instr_done_o),
    .illegal_op_o(illegal_op_o), .bus_error_o(bus_error_o), .state_o(state_o)
  );

  assign outs = {pc_write_o, pc_write_beq_o, pc_write_bne_o, pc_src_o,
                 ir_write_o, i_or_d_o, mem_read_o, mem_write_o, mem_to_reg_o,
                 reg_dst_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                 instr_done_o, illegal_op_o, bus_error_o};

  // Pack named fields into the same order as outs
  function automatic logic [20:0] ev(
    input int pcw, input int beq, input int bne, input int pcs,
    input int irw, input int iord, input int mr, input int mw,
    input int m2r, input int rd, input int rw, input int sa,
    input int sb, input int op, input int done, input int ill, input int berr);
    return {pcw[0], beq[0], bne[0], pcs[1:0], irw[0], iord[0], mr[0], mw[0],
            m2r[0], rd[0], rw[0], sa[0], sb[1:0], op[2:0], done[0], ill[0], berr[0]};
  endfunction

  //                               pcw beq bne pcs irw iod mr mw m2r rd rw sa sb op done ill berr
  localparam logic [20:0] X_ZERO    = 21'd0;
  localparam logic [20:0] X_FETCH   = ev(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
  localparam logic [20:0] X_FETCH_W = ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
  localparam logic [20:0] X_DEC     = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 0, 0);
  localparam logic [20:0] X_DEC_ILL = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 0, 1, 0);
  localparam logic [20:0] X_EXR     = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
  localparam logic [20:0] X_WB_R    = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
  localparam logic [20:0] X_WB_I    = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
  localparam logic [20:0] X_MADDR   = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4, 0, 0, 0);
  localparam logic [20:0] X_MRD     = ev(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [20:0] X_MWR     = ev(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [20:0] X_MWR_D   = ev(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  localparam logic [20:0] X_WBM     = ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
  localparam logic [20:0] X_BEQ     = ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0);
  localparam logic [20:0] X_BNE     = ev(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0);
  localparam logic [20:0] X_JUMP    = ev(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  localparam logic [20:0] X_JAL     = ev(1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
  localparam logic [20:0] X_HALT    = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global bound on run time
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Drive one cycle's inputs on the falling edge and let outputs settle
  task automatic drive(input logic rdy, input logic [5:0] op);
    @(negedge clk);
    mem_ready_i = rdy;
    opcode_i    = op;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready_i = 1'b0; opcode_i = 6'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (outs !== X_ZERO) begin errors++; $display("FAIL reset_hold: got %h expected %h", outs, X_ZERO); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (outs !== X_ZERO) begin errors++; $display("FAIL idle_after_release: got %h expected %h", outs, X_ZERO); end
  endtask

  task automatic test_r_type();
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL r_fetch: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h00);
    checks++; if (outs !== X_DEC) begin errors++; $display("FAIL r_decode: got %h expected %h", outs, X_DEC); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_EXR) begin errors++; $display("FAIL r_exec: got %h expected %h", outs, X_EXR); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_WB_R) begin errors++; $display("FAIL r_wb: got %h expected %h", outs, X_WB_R); end
  endtask

  // Ready arriving in the 15th FETCH cycle must still win over the timeout
  task automatic test_timeout_boundary();
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 6'h3F);
      checks++; if (outs !== X_FETCH_W) begin errors++; $display("FAIL bound_wait%0d: got %h expected %h", i, outs, X_FETCH_W); end
    end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL bound_ready: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h04);
    checks++; if (outs !== X_DEC) begin errors++; $display("FAIL bound_decode: got %h expected %h", outs, X_DEC); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_BEQ) begin errors++; $display("FAIL bound_beq: got %h expected %h", outs, X_BEQ); end
  endtask

  task automatic test_i_type();
    logic [5:0]  op_tab [4];
    logic [2:0]  alu_tab [4];
    logic [20:0] exp_exec;
    op_tab[0] = 6'h08; alu_tab[0] = 3'b100;
    op_tab[1] = 6'h0D; alu_tab[1] = 3'b001;
    op_tab[2] = 6'h0C; alu_tab[2] = 3'b010;
    op_tab[3] = 6'h0F; alu_tab[3] = 3'b000;
    for (int i = 0; i < 4; i++) begin
      exp_exec = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, int'(alu_tab[i]), 0, 0, 0);
      drive(1'b1, 6'h3F);
      checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL i%0h_fetch: got %h expected %h", op_tab[i], outs, X_FETCH); end
      drive(1'b1, op_tab[i]);
      checks++; if (outs !== X_DEC) begin errors++; $display("FAIL i%0h_decode: got %h expected %h", op_tab[i], outs, X_DEC); end
      drive(1'b1, 6'h00);
      checks++; if (outs !== exp_exec) begin errors++; $display("FAIL i%0h_exec: got %h expected %h", op_tab[i], outs, exp_exec); end
      drive(1'b1, 6'h00);
      checks++; if (outs !== X_WB_I) begin errors++; $display("FAIL i%0h_wb: got %h expected %h", op_tab[i], outs, X_WB_I); end
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL beq_fetch: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h04);
    checks++; if (outs !== X_DEC) begin errors++; $display("FAIL beq_decode: got %h expected %h", outs, X_DEC); end
    drive(1'b1, 6'h05);
    checks++; if (outs !== X_BEQ) begin errors++; $display("FAIL beq_branch: got %h expected %h", outs, X_BEQ); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL bne_fetch: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h05);
    checks++; if (outs !== X_DEC) begin errors++; $display("FAIL bne_decode: got %h expected %h", outs, X_DEC); end
    drive(1'b1, 6'h04);
    checks++; if (outs !== X_BNE) begin errors++; $display("FAIL bne_branch: got %h expected %h", outs, X_BNE); end
  endtask

  task automatic test_sw();
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL sw_fetch: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h2B);
    checks++; if (outs !== X_DEC) begin errors++; $display("FAIL sw_decode: got %h expected %h", outs, X_DEC); end
    drive(1'b1, 6'h23);
    checks++; if (outs !== X_MADDR) begin errors++; $display("FAIL sw_addr: got %h expected %h", outs, X_MADDR); end
    drive(1'b0, 6'h23);
    checks++; if (outs !== X_MWR) begin errors++; $display("FAIL sw_wait: got %h expected %h", outs, X_MWR); end
    drive(1'b1, 6'h23);
    checks++; if (outs !== X_MWR_D) begin errors++; $display("FAIL sw_done: got %h expected %h", outs, X_MWR_D); end
  endtask

  // LW with three wait cycles: eight cycles, then back in FETCH
  task automatic test_lw_wait();
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL lw_fetch: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h23);
    checks++; if (outs !== X_DEC) begin errors++; $display("FAIL lw_decode: got %h expected %h", outs, X_DEC); end
    drive(1'b1, 6'h2B);
    checks++; if (outs !== X_MADDR) begin errors++; $display("FAIL lw_addr: got %h expected %h", outs, X_MADDR); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'h2B);
      checks++; if (outs !== X_MRD) begin errors++; $display("FAIL lw_wait%0d: got %h expected %h", i, outs, X_MRD); end
    end
    drive(1'b1, 6'h2B);
    checks++; if (outs !== X_MRD) begin errors++; $display("FAIL lw_ready: got %h expected %h", outs, X_MRD); end
    drive(1'b1, 6'h2B);
    checks++; if (outs !== X_WBM) begin errors++; $display("FAIL lw_wb: got %h expected %h", outs, X_WBM); end
    drive(1'b0, 6'h3F);
    checks++; if (outs !== X_FETCH_W) begin errors++; $display("FAIL lw_next_fetch: got %h expected %h", outs, X_FETCH_W); end
  endtask

  task automatic test_illegal();
    drive(1'b1, 6'h00);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL ill_fetch: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_DEC_ILL) begin errors++; $display("FAIL ill_decode: got %h expected %h", outs, X_DEC_ILL); end
    drive(1'b0, 6'h3F);
    checks++; if (outs !== X_FETCH_W) begin errors++; $display("FAIL ill_refetch: got %h expected %h", outs, X_FETCH_W); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL j_fetch: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h02);
`ifdef MULTICYCLE_JUMP_EN
    checks++; if (outs !== X_DEC) begin errors++; $display("FAIL j_decode: got %h expected %h", outs, X_DEC); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_JUMP) begin errors++; $display("FAIL j_jump: got %h expected %h", outs, X_JUMP); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL jal_fetch: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h03);
    checks++; if (outs !== X_DEC) begin errors++; $display("FAIL jal_decode: got %h expected %h", outs, X_DEC); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_JAL) begin errors++; $display("FAIL jal_jump: got %h expected %h", outs, X_JAL); end
`else
    checks++; if (outs !== X_DEC_ILL) begin errors++; $display("FAIL j_decode_illegal: got %h expected %h", outs, X_DEC_ILL); end
    drive(1'b0, 6'h3F);
    checks++; if (outs !== X_FETCH_W) begin errors++; $display("FAIL j_refetch: got %h expected %h", outs, X_FETCH_W); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_FETCH) begin errors++; $display("FAIL rm_fetch: got %h expected %h", outs, X_FETCH); end
    drive(1'b1, 6'h00);
    checks++; if (outs !== X_DEC) begin errors++; $display("FAIL rm_decode: got %h expected %h", outs, X_DEC); end
    drive(1'b1, 6'h3F);
    checks++; if (outs !== X_EXR) begin errors++; $display("FAIL rm_exec: got %h expected %h", outs, X_EXR); end
    reset = 1'b0;
    #1;
    checks++; if (outs !== X_ZERO) begin errors++; $display("FAIL rm_async_zero: got %h expected %h", outs, X_ZERO); end
    @(negedge clk);
    checks++; if (outs !== X_ZERO) begin errors++; $display("FAIL rm_held_zero: got %h expected %h", outs, X_ZERO); end
    reset = 1'b1;
    #1;
    checks++; if (outs !== X_ZERO) begin errors++; $display("FAIL rm_idle: got %h expected %h", outs, X_ZERO); end
    drive(1'b0, 6'h3F);
    checks++; if (outs !== X_FETCH_W) begin errors++; $display("FAIL rm_fetch_after: got %h expected %h", outs, X_FETCH_W); end
  endtask

  // Fifteen waiting FETCH cycles -> HALT, sticky until reset
  task automatic test_timeout_halt();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 6'h3F);
      checks++; if (outs !== X_FETCH_W) begin errors++; $display("FAIL to_wait%0d: got %h expected %h", i, outs, X_FETCH_W); end
    end
    drive(1'b0, 6'h3F);
    checks++; if (outs !== X_HALT) begin errors++; $display("FAIL to_halt: got %h expected %h", outs, X_HALT); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'h00);
      checks++; if (outs !== X_HALT) begin errors++; $display("FAIL to_sticky%0d: got %h expected %h", i, outs, X_HALT); end
    end
    reset = 1'b0;
    #1;
    checks++; if (outs !== X_ZERO) begin errors++; $display("FAIL to_cleared: got %h expected %h", outs, X_ZERO); end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 6'h3F);
    checks++; if (outs !== X_FETCH_W) begin errors++; $display("FAIL to_restart: got %h expected %h", outs, X_FETCH_W); end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_timeout_boundary();
    test_i_type();
    test_branch();
    test_sw();
    test_lw_wait();
    test_illegal();
    test_reset_mid();
    test_timeout_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
